// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: tracks the writers in E/M/W and
// decides D-stage stall and operand forwarding from their tnew/tuse timing.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic             d_use_rs,
    input  logic             d_tuse_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rt,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_we,
    input  logic [4:0]       d_dst,
    input  logic [1:0]       d_tnew,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
    } slot_t;

    slot_t slot_e, slot_m, slot_w;
    logic [2:0] res_rs, res_rt;

    function automatic logic hit(input slot_t s, input logic [4:0] r);
        return s.valid && (s.dst != 5'd0) && (s.dst == r);
    endfunction

    // Returns {stall, fwd}; only the youngest matching slot is consulted.
    function automatic logic [2:0] resolve(input slot_t e, input slot_t m, input slot_t w,
                                           input logic rd, input logic [4:0] r,
                                           input logic [1:0] tuse);
        logic       stl;
        logic [1:0] fwd;
        stl = 1'b0;
        fwd = 2'd0;
        if (rd && r != 5'd0) begin
            if (hit(e, r)) begin
                stl = e.tnew > tuse;
                fwd = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
            end else if (hit(m, r)) begin
                stl = m.tnew > tuse;
                fwd = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
            end else if (hit(w, r)) begin
                fwd = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
            end
        end
        return {stl, fwd};
    endfunction

    always_comb begin
        res_rs = resolve(slot_e, slot_m, slot_w, d_use_rs, d_rs, {1'b0, d_tuse_rs});
        res_rt = resolve(slot_e, slot_m, slot_w, d_use_rt, d_rt, d_tuse_rt);
        stall  = !flush && (res_rs[2] || res_rt[2]);
        fwd_rs = res_rs[1:0];
        fwd_rt = res_rt[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_e    <= '0;
            slot_m    <= '0;
            slot_w    <= '0;
            stall_cnt <= '0;
        end else begin
            // A stalled or flushed D instruction enters E as a bubble.
            if (stall || flush) slot_e <= '0;
            else                slot_e <= '{valid: d_we, dst: d_dst, tnew: d_tnew};
            slot_m <= '{valid: slot_e.valid, dst: slot_e.dst,
                        tnew: (slot_e.tnew == 2'd0) ? 2'd0 : slot_e.tnew - 2'd1};
            slot_w <= '{valid: slot_m.valid, dst: slot_m.dst, tnew: 2'd0};
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one task per scenario, expected values
// worked out by hand from the tnew/tuse rules.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic       d_use_rs = 1'b0, d_tuse_rs = 1'b0, d_use_rt = 1'b0, d_we = 1'b0, flush = 1'b0;
    logic [1:0] d_tuse_rt = '0, d_tnew = '0;
    logic       stall, stall2;
    logic [1:0] fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;
    int checks = 0;
    int failures = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_use_rs(d_use_rs), .d_tuse_rs(d_tuse_rs),
        .d_rt(d_rt), .d_use_rt(d_use_rt), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_dst(d_dst),
        .d_tnew(d_tnew), .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_use_rs(d_use_rs), .d_tuse_rs(d_tuse_rs),
        .d_rt(d_rt), .d_use_rt(d_use_rt), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_dst(d_dst),
        .d_tnew(d_tnew), .flush(flush), .stall(stall2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2),
        .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic urs, input logic [4:0] rs, input logic trs,
                         input logic urt, input logic [4:0] rt, input logic [1:0] trt,
                         input logic we, input logic [4:0] dst, input logic [1:0] tn);
        d_use_rs = urs; d_rs = rs; d_tuse_rs = trs;
        d_use_rt = urt; d_rt = rt; d_tuse_rt = trt;
        d_we = we; d_dst = dst; d_tnew = tn;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        flush = 1'b0;
        rst_n = 1'b0;
        nop();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 8, 0, 1, 9, 0, 1, 8, 2);
        tick();
        drive(1, 8, 0, 1, 9, 0, 1, 9, 2);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall); end
        checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin failures++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_rs, fwd_rt); end
        checks++; if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, stall_cnt2); end
        rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_release_stall got=%0d exp=0", stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2);                 // lw $8
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_lw_stall got=%0d exp=0", stall); end
        tick();
        drive(1, 8, 1, 0, 0, 0, 1, 10, 1);                // add $10 <- $8
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%0d exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0d exp=0", stall); end
        tick();
        nop();
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_branch_after_alu();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1);                 // ori $9
        tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0);                 // beq $9
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL br_alu_stall got=%0d exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd2) begin failures++; $display("FAIL br_alu_fwd got=%0d/%0d exp=0/2", stall, fwd_rs); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 2);                 // lw $9
        tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL br_lw_stall1 got=%0d exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b1 || fwd_rs !== 2'd0) begin failures++; $display("FAIL br_lw_stall2 got=%0d/%0d exp=1/0", stall, fwd_rs); end
        tick();
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd3) begin failures++; $display("FAIL br_lw_fwd got=%0d/%0d exp=0/3", stall, fwd_rs); end
        tick();
        nop();
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL br_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_youngest_wins();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 0);                 // ori $5
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 0);                 // ori $5
        tick();
        drive(1, 4, 0, 1, 5, 2, 0, 0, 0);                 // sw $5 -> 0($4)
        checks++; if (stall !== 1'b0 || fwd_rt !== 2'd1) begin failures++; $display("FAIL yw_sw got=%0d/%0d exp=0/1", stall, fwd_rt); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 2);                 // lw $5
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 0);                 // ori $5 shadows the load
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd1) begin failures++; $display("FAIL yw_shadow got=%0d/%0d exp=0/1", stall, fwd_rs); end
        drive(0, 5, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_rs !== 2'd0) begin failures++; $display("FAIL yw_nouse got=%0d exp=0", fwd_rs); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 2);                 // lw $0
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin failures++; $display("FAIL zero_reg got=%0d/%0d/%0d exp=0/0/0", stall, fwd_rs, fwd_rt); end
        tick();
        nop();
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2);                 // lw $8
        tick();
        drive(1, 8, 1, 0, 0, 0, 1, 10, 2);                // writes $10, reads $8
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_pre got=%0d exp=1", stall); end
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%0d exp=0", stall); end
        tick();
        flush = 1'b0;
        drive(1, 10, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin failures++; $display("FAIL fl_bubble got=%0d/%0d exp=0/0", stall, fwd_rs); end
        drive(0, 0, 0, 1, 8, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_m_adv got=%0d exp=1", stall); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL fl_cnt got=%0d exp=0", stall_cnt); end
        nop();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 7, 0);                 // ori $7
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 8, 2);                 // lw $8
        tick();
        drive(1, 8, 0, 1, 7, 2, 0, 0, 0);
        checks++; if (stall !== 1'b1 || fwd_rt !== 2'd2) begin failures++; $display("FAIL rm_pre got=%0d/%0d exp=1/2", stall, fwd_rt); end
        tick();
        checks++; if (stall !== 1'b1 || fwd_rt !== 2'd3 || stall_cnt !== 16'd1) begin failures++; $display("FAIL rm_pre2 got=%0d/%0d/%0d exp=1/3/1", stall, fwd_rt, stall_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL rm_async got=%0d/%0d/%0d/%0d exp=0/0/0/0", stall, fwd_rs, fwd_rt, stall_cnt); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || fwd_rt !== 2'd0) begin failures++; $display("FAIL rm_release got=%0d/%0d exp=0/0", stall, fwd_rt); end
        nop();
    endtask

    task automatic test_saturation();
        do_reset();
        // Reads and rewrites $9 as a load: stalls twice every three cycles.
        drive(1, 9, 0, 0, 0, 0, 1, 9, 2);
        checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL sat_c0 got=%0d exp=0", stall2); end
        tick();
        tick();
        tick();
        checks++; if (stall2 !== 1'b0 || fwd_rs2 !== 2'd3 || stall_cnt2 !== 2'd2) begin failures++; $display("FAIL sat_c3 got=%0d/%0d/%0d exp=0/3/2", stall2, fwd_rs2, stall_cnt2); end
        tick();
        checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL sat_c4 got=%0d exp=1", stall2); end
        tick();
        checks++; if (stall_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_hit got=%0d exp=3", stall_cnt2); end
        tick();
        tick();
        tick();
        tick();
        checks++; if (stall_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", stall_cnt2); end
        checks++; if (stall_cnt !== 16'd6) begin failures++; $display("FAIL sat_wide got=%0d exp=6", stall_cnt); end
        nop();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_after_alu();
        test_youngest_wins();
        test_zero_reg();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
